uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
Serial-to-parallel UART receiver and the receive-side counterpart of the existing transmitter. Frame format: 1 start bit (0), 8 data bits LSB first, then stop bit(s) (1). The transmitter sends 2 stop bits; this block checks only the first and tolerates 1 or more. Sits between the external RxD pin and the loopback/host logic, and presents each received byte with a one-cycle strobe.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line bit rate
OVERSAMPLE, 16, sample ticks per bit period (power of 2, >= 8)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
RxD  input  1  serial line, asynchronous to clk, idle high
data  output  8  last correctly framed byte, held until next good frame
data_ready  output  1  one-clk pulse when data is updated
framing_error  output  1  one-clk pulse when the stop bit is sampled as 0
busy  output  1  high from start-bit detect until stop-bit decision

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high. All flops clear on rst assertion, with no clk edge required.
- Reset values: data=8'h00, data_ready=0, framing_error=0, busy=0, state=IDLE, synchronizer flops=1 (line idle).
- Input sync: RxD passes through 2 flops (rx_s); all logic uses rx_s only. A third flop (rx_d) detects falling edges.
- Oversample tick:
  - One-clk pulse every DIV = CLK_FREQ/(BAUD*OVERSAMPLE) clocks (integer floor; 27 at the defaults).
  - Tick counter free-runs only while busy, and is cleared to 0 in IDLE so phase aligns to the start edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on rx_d=1 & rx_s=0, go to START, clear sample count s=0 and bit index i=0, and set busy=1.
  - START: count ticks. At s=OVERSAMPLE/2-1 (mid start bit), if bit value=1 it is a glitch: return to IDLE, busy=0, no outputs. Else reset s and go to DATA.
  - DATA: at each mid-bit point (s=OVERSAMPLE-1 after the start-bit midpoint), shift the bit into shift_reg[7] with a right shift so LSB-first arrives correctly. Then i++; after i=7 go to STOP.
  - STOP: at the mid-bit point, if bit=1, data<=shift_reg and pulse data_ready. If bit=0, pulse framing_error and leave data unchanged. Either way go to IDLE and set busy=0 in the same cycle.
- Bit value: majority of rx_s at the 3 ticks centred on the mid-bit point (samples OVERSAMPLE/2-2, -1, 0 relative to the bit start). This is implemented by counting ones in a 3-bit window.
- data_ready and framing_error are mutually exclusive and never high for more than one clk.
- Line held low after a framing error (break): there is no new falling edge, so the block stays in IDLE until the line returns high and falls again.
- Back-to-back frames: a falling edge is accepted in the first IDLE cycle after STOP, so 1-stop-bit framing works.
- Reset mid-frame: immediate IDLE, partial byte discarded, no strobe, data returns to 8'h00.
- Latency: data_ready rises about 9.5 bit periods plus 3 clk after the start-bit falling edge on RxD.

Decomposition:
- Shared package uart_pkg: the FSM state encoding (IDLE/START/DATA/STOP) and a localparam function computing DIV from CLK_FREQ, BAUD, OVERSAMPLE. The transmitter's baud generator reuses the same function.
- One sub-module: oversample_tick_gen (inputs clk, rst, enable; output tick; parameter DIV). It is distinct from the existing baud_generator because it must clear on enable=0 for phase alignment.

Test Plan:
- Reset then idle line (RxD=1) for 20 bit periods -> busy=0, no data_ready/framing_error, data=8'h00.
- Transmit 0x55, then 0xA3, with 2 stop bits at 115200 baud -> exactly one data_ready per frame, with data=8'h55 then 8'hA3 and busy low between frames.
- Glitch: RxD low for 4 oversample ticks, then high -> returns to IDLE, busy pulses, no strobe, data unchanged.
- Frame 0x3C with stop bit forced 0, then line high, then a good frame 0x81 -> framing_error pulse with data unchanged, then data_ready with data=8'h81.
- Single-sample noise (1 tick inverted at mid-bit of bit 3) on byte 0xF0 -> majority vote recovers, data=8'hF0.
- Assert rst during DATA bit 5 of 0x7E, release, then send 0x12 -> no strobe for the aborted frame, data=8'h00 after reset, then data=8'h12 with one data_ready; also send a 1-stop-bit burst 0x01,0x02 back-to-back -> both received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and the oversample divider
// used by both the receive tick generator and the transmit baud generator.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Integer floor; the resulting rate error is absorbed by mid-bit sampling.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

  function automatic logic majority3(input logic [2:0] w);
    logic [1:0] ones;
    ones = 2'(w[0]) + 2'(w[1]) + 2'(w[2]);
    return (ones >= 2'd2);
  endfunction

endpackage

// File: rtl/oversample_tick_gen.sv
// One-clk tick every DIV clocks while enabled; held at zero when disabled so
// the tick phase restarts from the moment enable rises.
module oversample_tick_gen #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 2-flop input sync, 3-sample majority vote at mid-bit
// and single-cycle data_ready / framing_error strobes (mutually exclusive).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       data_ready,
  output logic       framing_error,
  output logic       busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT = SW'(OVERSAMPLE - 1);

  logic            rx_m, rx_s, rx_d;
  rx_state_t       state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [2:0]      i, i_n;
  logic [7:0]      shift_reg, shift_n, data_n;
  logic [1:0]      win;
  logic            tick, bit_val, dr_n, fe_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= RxD;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  oversample_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (busy),
    .tick   (tick)
  );

  assign busy = (state != IDLE);

  // The two previous tick samples plus the current one form the vote window.
  assign bit_val = majority3({win, rx_s});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      s             <= '0;
      i             <= '0;
      shift_reg     <= '0;
      win           <= 2'b11;
      data          <= 8'h00;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_n;
      s             <= s_n;
      i             <= i_n;
      shift_reg     <= shift_n;
      data          <= data_n;
      data_ready    <= dr_n;
      framing_error <= fe_n;
      if (tick) begin
        win <= {win[0], rx_s};
      end
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    i_n     = i;
    shift_n = shift_reg;
    data_n  = data;
    dr_n    = 1'b0;
    fe_n    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_d && !rx_s) begin
          state_n = START;
          s_n     = '0;
          i_n     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s == S_MID) begin
            s_n     = '0;
            state_n = bit_val ? IDLE : DATA;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == S_BIT) begin
            s_n     = '0;
            shift_n = {bit_val, shift_reg[7:1]};
            if (i == 3'd7) begin
              state_n = STOP;
            end else begin
              i_n = i + 1'b1;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s == S_BIT) begin
            s_n     = '0;
            state_n = IDLE;
            if (bit_val) begin
              data_n = shift_reg;
              dr_n   = 1'b1;
            end else begin
              fe_n = 1'b1;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: serial frames are generated bit by bit,
// expected bytes queued on send and popped on each data_ready strobe.
module tb_uart_receiver;

  localparam int CLK_FREQ   = 50000000;
  localparam int BAUD       = 115200;
  localparam int OVERSAMPLE = 16;
  localparam int DIV        = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int BIT_CLKS   = DIV * OVERSAMPLE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RxD = 1'b1;
  logic [7:0] data;
  logic       data_ready, framing_error, busy;

  int errors = 0, checks = 0;
  int dr_count = 0, fe_count = 0;
  int cyc = 0, start_cyc = 0, last_dr_cyc = 0;
  logic dr_prev = 1'b0, fe_prev = 1'b0;
  logic [7:0] exp_b;
  logic [7:0] exp_q[$];

  uart_receiver #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .RxD           (RxD),
    .data          (data),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .busy          (busy)
  );

  // clock/reset
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      dr_prev = 1'b0;
      fe_prev = 1'b0;
    end else begin
      if (data_ready) begin
        dr_count++;
        last_dr_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_data_ready data=%h, no byte expected", data);
        end else begin
          exp_b = exp_q.pop_front();
          if (data !== exp_b) begin
            errors++;
            $display("FAIL rx_byte got=%h exp=%h", data, exp_b);
          end
        end
      end
      if (framing_error) fe_count++;
      if (data_ready || framing_error) begin
        checks++;
        if (!((data_ready ^ framing_error) && !dr_prev && !fe_prev)) begin
          errors++;
          $display("FAIL strobe_shape dr=%b fe=%b dr_prev=%b fe_prev=%b exp single exclusive pulse",
                   data_ready, framing_error, dr_prev, fe_prev);
        end
      end
      dr_prev = data_ready;
      fe_prev = framing_error;
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      RxD = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nstop,
                            input int noise_bit, input int abort_bit);
    logic [9:0] bits;
    logic v;
    bits = {stop_bit, b, 1'b0};
    if (stop_bit && abort_bit < 0) exp_q.push_back(b);
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        @(negedge clk);
        if (abort_bit >= 0 && j == abort_bit + 1 && c == BIT_CLKS / 2) begin
          rst = 1'b1;
          RxD = 1'b1;
          return;
        end
        v = bits[j];
        if (noise_bit >= 0 && j == noise_bit + 1 && c >= 178 && c <= 202) v = ~v;
        RxD = v;
        if (j == 0 && c == 0) start_cyc = cyc;
      end
    end
    for (int k = 1; k < nstop; k++) idle(BIT_CLKS);
  endtask

  task automatic wait_not_busy(input string name);
    int k;
    k = 0;
    while (busy && k < 4000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy=%b exp=0 after wait", name, busy);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    RxD = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks += 4;
    if (data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
    if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_dr got=%b exp=0", data_ready); end
    if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_fe got=%b exp=0", framing_error); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int busy_seen, dr0, fe0;
    busy_seen = 0;
    dr0 = dr_count;
    fe0 = fe_count;
    repeat (20 * BIT_CLKS) begin
      @(negedge clk);
      RxD = 1'b1;
      if (busy) busy_seen++;
    end
    checks += 4;
    if (busy_seen != 0) begin errors++; $display("FAIL idle_busy cycles=%0d exp=0", busy_seen); end
    if (dr_count != dr0) begin errors++; $display("FAIL idle_dr count=%0d exp=%0d", dr_count, dr0); end
    if (fe_count != fe0) begin errors++; $display("FAIL idle_fe count=%0d exp=%0d", fe_count, fe0); end
    if (data !== 8'h00) begin errors++; $display("FAIL idle_data got=%h exp=00", data); end
  endtask

  task automatic test_frames();
    int dr0, lat;
    dr0 = dr_count;
    send_frame(8'h55, 1'b1, 2, -1, -1);
    wait_not_busy("frame55_busy");
    lat = last_dr_cyc - start_cyc;
    checks += 2;
    if (dr_count != dr0 + 1) begin errors++; $display("FAIL frame55_count got=%0d exp=%0d", dr_count - dr0, 1); end
    if (lat < 4100 || lat > 4115) begin errors++; $display("FAIL frame55_latency got=%0d exp=4100..4115", lat); end
    send_frame(8'hA3, 1'b1, 2, -1, -1);
    wait_not_busy("frameA3_busy");
    checks += 3;
    if (dr_count != dr0 + 2) begin errors++; $display("FAIL frameA3_count got=%0d exp=%0d", dr_count - dr0, 2); end
    if (data !== 8'hA3) begin errors++; $display("FAIL frameA3_hold got=%h exp=a3", data); end
    if (fe_count != 0) begin errors++; $display("FAIL frames_fe got=%0d exp=0", fe_count); end
  endtask

  task automatic test_glitch();
    int busy_seen, dr0;
    busy_seen = 0;
    dr0 = dr_count;
    repeat (4 * DIV) begin
      @(negedge clk);
      RxD = 1'b0;
      if (busy) busy_seen++;
    end
    repeat (20 * DIV) begin
      @(negedge clk);
      RxD = 1'b1;
      if (busy) busy_seen++;
    end
    checks += 4;
    if (busy_seen == 0) begin errors++; $display("FAIL glitch_busy_pulse cycles=%0d exp>0", busy_seen); end
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
    if (dr_count != dr0) begin errors++; $display("FAIL glitch_dr got=%0d exp=0", dr_count - dr0); end
    if (data !== 8'hA3) begin errors++; $display("FAIL glitch_data got=%h exp=a3", data); end
  endtask

  task automatic test_framing();
    int dr0, fe0;
    dr0 = dr_count;
    fe0 = fe_count;
    send_frame(8'h3C, 1'b0, 1, -1, -1);
    idle(2 * BIT_CLKS);
    checks += 3;
    if (fe_count != fe0 + 1) begin errors++; $display("FAIL framing_fe got=%0d exp=1", fe_count - fe0); end
    if (dr_count != dr0) begin errors++; $display("FAIL framing_dr got=%0d exp=0", dr_count - dr0); end
    if (data !== 8'hA3) begin errors++; $display("FAIL framing_data got=%h exp=a3", data); end
    send_frame(8'h81, 1'b1, 2, -1, -1);
    wait_not_busy("framing_recover_busy");
    checks += 3;
    if (dr_count != dr0 + 1) begin errors++; $display("FAIL recover_dr got=%0d exp=1", dr_count - dr0); end
    if (data !== 8'h81) begin errors++; $display("FAIL recover_data got=%h exp=81", data); end
    if (fe_count != fe0 + 1) begin errors++; $display("FAIL recover_fe got=%0d exp=1", fe_count - fe0); end
  endtask

  task automatic test_noise();
    int dr0;
    dr0 = dr_count;
    send_frame(8'hF0, 1'b1, 2, 3, -1);
    wait_not_busy("noise_busy");
    checks += 2;
    if (dr_count != dr0 + 1) begin errors++; $display("FAIL noise_dr got=%0d exp=1", dr_count - dr0); end
    if (data !== 8'hF0) begin errors++; $display("FAIL noise_data got=%h exp=f0", data); end
  endtask

  task automatic test_reset_mid();
    int dr0;
    dr0 = dr_count;
    send_frame(8'h7E, 1'b1, 2, -1, 5);
    #1;
    checks += 2;
    if (data !== 8'h00) begin errors++; $display("FAIL midreset_data got=%h exp=00", data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    idle(2 * BIT_CLKS);
    checks++;
    if (dr_count != dr0) begin errors++; $display("FAIL midreset_dr got=%0d exp=0", dr_count - dr0); end
    send_frame(8'h12, 1'b1, 2, -1, -1);
    wait_not_busy("after_reset_busy");
    checks += 2;
    if (dr_count != dr0 + 1) begin errors++; $display("FAIL after_reset_dr got=%0d exp=1", dr_count - dr0); end
    if (data !== 8'h12) begin errors++; $display("FAIL after_reset_data got=%h exp=12", data); end
  endtask

  task automatic test_back_to_back();
    int dr0;
    dr0 = dr_count;
    send_frame(8'h01, 1'b1, 1, -1, -1);
    send_frame(8'h02, 1'b1, 1, -1, -1);
    idle(BIT_CLKS);
    wait_not_busy("b2b_busy");
    checks += 3;
    if (dr_count != dr0 + 2) begin errors++; $display("FAIL b2b_dr got=%0d exp=2", dr_count - dr0); end
    if (data !== 8'h02) begin errors++; $display("FAIL b2b_data got=%h exp=02", data); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_frames();
    test_glitch();
    test_framing();
    test_noise();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
